// File: rtl/t5_pkg.sv
// Shared constants for the t5 writeback slice: major opcodes and load access sizes.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

endpackage

// File: rtl/t5_wback_if.sv
// Writeback result bundle: register-file write port plus per-hart replay/error status.
interface t5_wback_if #(
  parameter int XLEN  = 32,
  parameter int HARTW = 2
);

  logic [XLEN-1:0]  rd0d;
  logic [4:0]       rd0a;
  logic             rd0e;
  logic [HARTW-1:0] mhart;
  logic             mrpl;
  logic             mberr;

  modport master (output rd0d, rd0a, rd0e, mhart, mrpl, mberr);
  modport slave  (input  rd0d, rd0a, rd0e, mhart, mrpl, mberr);

endinterface

// File: rtl/t5_ldext.sv
// Load lane alignment and sign/zero extension, plus legality check of the byte-lane select.
module t5_ldext
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN/8-1:0] xsel,
  input  logic [2:0]        fn3,
  input  logic [XLEN-1:0]   dwb_dti,
  output logic [XLEN-1:0]   dext,
  output logic              ill
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  size_e           size;
  logic [OW-1:0]   off;
  logic [63:0]     m64;
  logic [15:0]     want;
  logic [2:0]      amask;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] msk;
  logic [XLEN-1:0] top;
  logic            sgn;

  always_comb begin
    size = size_e'(fn3[1:0]);
    off  = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (xsel[i]) off = OW'(i);
    end
    case (size)
      SZ_B:    begin m64 = 64'h0000_0000_0000_00FF; amask = 3'd0; want = 16'h0001; end
      SZ_H:    begin m64 = 64'h0000_0000_0000_FFFF; amask = 3'd1; want = 16'h0003; end
      SZ_W:    begin m64 = 64'h0000_0000_FFFF_FFFF; amask = 3'd3; want = 16'h000F; end
      default: begin m64 = 64'hFFFF_FFFF_FFFF_FFFF; amask = 3'd7; want = 16'h00FF; end
    endcase
    want = want << off;
    sh   = dwb_dti >> {off, 3'b000};
    msk  = m64[XLEN-1:0];
    top  = msk & ~(msk >> 1);
    sgn  = !fn3[2] && ((sh & top) != '0);
    // the lane pattern must be exactly the size mask at a size-aligned offset
    ill  = (want != {{(16 - NB){1'b0}}, xsel}) ||
           ((3'(off) & amask) != 3'd0) ||
           ((XLEN == 32) && (size == SZ_D));
    dext = (sh & msk) | (sgn ? ~msk : '0);
  end

endmodule

// File: rtl/t5_wback.sv
// Writeback stage: D->X->M decode pipeline, load resolution in X, per-hart load replay in M.
module t5_wback
  import t5_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HARTW = 2,
  parameter int RTRY  = 15
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              sena,
  input  logic [31:0]       iwb_dat,
  input  logic              xstb,
  input  logic              xwre,
  input  logic [XLEN/8-1:0] xsel,
  input  logic [XLEN-1:0]   dwb_dti,
  input  logic              dwb_ack,
  input  logic [XLEN-1:0]   mpc,
  input  logic [XLEN-1:0]   malu,
  t5_wback_if.master        wb
);

  localparam int NHART = 2 ** HARTW;

  logic [4:0]       dopc, drd;
  logic             dwr, dld;
  logic [4:0]       xrd;
  logic             xwr, xld, xload;
  logic [2:0]       xfn3;
  logic [4:0]       mrd;
  logic             mwr, mld, mnak, mill;
  logic [XLEN-1:0]  dext, lext;
  logic             lill;
  logic [3:0]       cnt [NHART];
  logic [HARTW-1:0] hart;
  logic             tmo, rpl;
  logic             unused_bits;

  assign dopc  = iwb_dat[6:2];
  assign drd   = iwb_dat[11:7];
  assign dwr   = (drd != 5'd0) && (dopc != OPC_STORE) && (dopc != OPC_BRANCH);
  assign dld   = (dopc == OPC_LOAD);
  assign xload = xld && xstb && !xwre;

  t5_ldext #(.XLEN(XLEN)) u_ldext (
    .xsel    (xsel),
    .fn3     (xfn3),
    .dwb_dti (dwb_dti),
    .dext    (lext),
    .ill     (lill)
  );

  always_ff @(posedge sclk) begin
    if (srst) begin
      xrd  <= '0;
      xwr  <= 1'b0;
      xld  <= 1'b0;
      xfn3 <= '0;
      mrd  <= '0;
      mwr  <= 1'b0;
      mld  <= 1'b0;
      mnak <= 1'b0;
      mill <= 1'b0;
      dext <= '0;
      for (int h = 0; h < NHART; h++) cnt[h] <= '0;
    end else if (sena) begin
      xrd  <= drd;
      xwr  <= dwr;
      xld  <= dld;
      xfn3 <= iwb_dat[14:12];
      mrd  <= xrd;
      mwr  <= xwr;
      mld  <= xld;
      // a nak'd or illegal load carries zero data so nothing stale can reach rd0d
      if (xload) begin
        if (lill) begin
          dext <= '0;
          mill <= 1'b1;
          mnak <= 1'b0;
        end else if (dwb_ack) begin
          dext <= lext;
          mill <= 1'b0;
          mnak <= 1'b0;
        end else begin
          dext <= '0;
          mill <= 1'b0;
          mnak <= 1'b1;
        end
      end else begin
        mill <= 1'b0;
        mnak <= 1'b0;
      end
      if (rpl) cnt[hart] <= cnt[hart] + 4'd1;
      else if (mld) cnt[hart] <= '0;
    end
  end

  assign hart = mpc[HARTW-1:0];
  assign tmo  = mld && mnak && (cnt[hart] == 4'(RTRY));
  assign rpl  = mld && mnak && !tmo && !mill;

  assign wb.rd0d  = mld ? dext : malu;
  assign wb.rd0a  = mrd;
  assign wb.rd0e  = mwr && !(mld && (mnak || mill));
  assign wb.mhart = hart;
  assign wb.mrpl  = rpl;
  assign wb.mberr = mld && (mill || tmo);

  assign unused_bits = ^{iwb_dat[31:15], iwb_dat[1:0], mpc[XLEN-1:HARTW]};

endmodule

// File: tb/tb_t5_wback.sv
// Scoreboard bench for t5_wback: driver pushes expected M-stage results, negedge monitor pops and compares.
module tb_t5_wback;
  import t5_pkg::*;

  localparam int XLEN  = 32;
  localparam int HARTW = 2;
  localparam int RTRY  = 15;
  localparam logic [4:0]  OPC_OPIMM = 5'b00100;
  localparam logic [31:0] IDLE_ALU  = 32'h0BAD_F00D;

  logic        sclk = 1'b0;
  logic        srst, sena;
  logic [31:0] iwb_dat;
  logic        xstb, xwre, dwb_ack;
  logic [3:0]  xsel;
  logic [31:0] dwb_dti, mpc, malu;

  t5_wback_if #(.XLEN(XLEN), .HARTW(HARTW)) wb ();

  t5_wback #(.XLEN(XLEN), .HARTW(HARTW), .RTRY(RTRY)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .iwb_dat(iwb_dat),
    .xstb(xstb), .xwre(xwre), .xsel(xsel), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mpc(mpc), .malu(malu), .wb(wb)
  );

  logic [7:0]  x64_sel;
  logic [2:0]  x64_fn3;
  logic [63:0] x64_dti, x64_ext;
  logic        x64_ill;

  t5_ldext #(.XLEN(64)) u_x64 (
    .xsel(x64_sel), .fn3(x64_fn3), .dwb_dti(x64_dti), .dext(x64_ext), .ill(x64_ill)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [31:0] iwb;
    logic        stb, wre;
    logic [3:0]  sel;
    logic [31:0] dti;
    logic        ack;
    logic [31:0] mpc, malu;
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
    logic        rpl, berr;
    logic [1:0]  hart;
    logic        stall;
  } rec_t;

  typedef struct {
    logic        e;
    logic [4:0]  a;
    logic [31:0] d;
    logic        rpl, berr;
    logic [1:0]  hart;
    string       tag;
  } exp_t;

  rec_t  vec[$];
  exp_t  exp_q[$];
  string phase;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  mon_en = 1'b0;
  logic  end_req = 1'b0;
  logic  x64_done = 1'b0;

  function automatic logic [31:0] ins(logic [4:0] opc, logic [2:0] fn3, logic [4:0] rd);
    return {17'd0, fn3, rd, opc, 2'b11};
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.iwb = ins(OPC_OPIMM, 3'b000, 5'd0);
    r.stb = 1'b0; r.wre = 1'b0; r.sel = 4'h0; r.dti = 32'h0; r.ack = 1'b0;
    r.mpc = 32'h0000_2000; r.malu = IDLE_ALU;
    r.e = 1'b0; r.a = 5'd0; r.d = IDLE_ALU; r.rpl = 1'b0; r.berr = 1'b0;
    r.hart = 2'd0; r.stall = 1'b0;
    return r;
  endfunction

  function automatic rec_t get(int idx);
    if (idx < 0 || idx >= vec.size()) return idle_rec();
    return vec[idx];
  endfunction

  task automatic add(input logic [31:0] iwb, input logic stb, input logic wre,
                     input logic [3:0] sel, input logic [31:0] dti, input logic ack,
                     input logic [1:0] hart, input logic [31:0] alu,
                     input logic e, input logic [4:0] a, input logic [31:0] d,
                     input logic rpl, input logic berr, input logic stall);
    rec_t r;
    r.iwb = iwb; r.stb = stb; r.wre = wre; r.sel = sel; r.dti = dti; r.ack = ack;
    r.mpc = 32'h0000_2000 | {30'd0, hart}; r.malu = alu;
    r.e = e; r.a = a; r.d = d; r.rpl = rpl; r.berr = berr; r.hart = hart; r.stall = stall;
    vec.push_back(r);
  endtask

  task automatic push_exp(input rec_t r, input string tag);
    exp_t x;
    x.e = r.e; x.a = r.a; x.d = r.d; x.rpl = r.rpl; x.berr = r.berr; x.hart = r.hart;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic drive_step(input int s);
    rec_t dr, xr, mr;
    dr = get(s);
    xr = get(s - 1);
    mr = get(s - 2);
    iwb_dat = dr.iwb;
    xstb = xr.stb; xwre = xr.wre; xsel = xr.sel; dwb_dti = xr.dti; dwb_ack = xr.ack;
    mpc = mr.mpc; malu = mr.malu;
    if (s < vec.size()) push_exp(dr, $sformatf("%s.%0d", phase, s));
    if (s < vec.size() && dr.stall) begin
      sena = 1'b0;
      repeat (3) @(posedge sclk);
      #1 sena = 1'b1;
    end
    @(posedge sclk);
    #1;
  endtask

  // the first two M slots of every run hold bubbles (reset state or a drained pipe)
  task automatic run(input int ndrain);
    push_exp(idle_rec(), {phase, ".b0"});
    push_exp(idle_rec(), {phase, ".b1"});
    for (int s = 0; s < vec.size() + ndrain; s++) drive_step(s);
  endtask

  task automatic do_reset();
    rec_t r;
    r = idle_rec();
    mon_en = 1'b0;
    srst = 1'b1;
    sena = 1'b1;
    iwb_dat = r.iwb; xstb = 1'b0; xwre = 1'b0; xsel = 4'h0; dwb_dti = 32'h0; dwb_ack = 1'b0;
    mpc = r.mpc; malu = r.malu;
    @(posedge sclk);
    #1;
    srst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  logic [7:0]  t_sel [5] = '{8'hFF, 8'hF0, 8'hF0, 8'h0C, 8'h0F};
  logic [2:0]  t_fn3 [5] = '{3'b011, 3'b010, 3'b110, 3'b001, 3'b011};
  logic [63:0] t_dti [5] = '{64'h0123_4567_89AB_CDEF, 64'h8000_0000_1111_1111,
                             64'h8000_0000_1111_1111, 64'h0000_0000_FEDC_0000,
                             64'h0123_4567_89AB_CDEF};
  logic [63:0] t_ext [5] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_8000_0000,
                             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FEDC, 64'h0};
  logic        t_ill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always @(negedge sclk) begin
    exp_t x;
    if (end_req) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else if (mon_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: DUT e=%0b rpl=%0b berr=%0b with no expected entry",
                 wb.rd0e, wb.mrpl, wb.mberr);
      end else begin
        x = exp_q[0];
        if (wb.rd0e !== x.e || wb.rd0a !== x.a || wb.rd0d !== x.d ||
            wb.mrpl !== x.rpl || wb.mberr !== x.berr || wb.mhart !== x.hart) begin
          n_bad++;
          $display("FAIL %s: got e=%0b a=%0d d=%h rpl=%0b berr=%0b hart=%0d, want e=%0b a=%0d d=%h rpl=%0b berr=%0b hart=%0d",
                   x.tag, wb.rd0e, wb.rd0a, wb.rd0d, wb.mrpl, wb.mberr, wb.mhart,
                   x.e, x.a, x.d, x.rpl, x.berr, x.hart);
        end
        if (sena) void'(exp_q.pop_front());
      end
    end else if (!x64_done) begin
      for (int i = 0; i < 5; i++) begin
        x64_sel = t_sel[i]; x64_fn3 = t_fn3[i]; x64_dti = t_dti[i];
        #1;
        n_cmp++;
        if (x64_ill !== t_ill[i] || (!t_ill[i] && x64_ext !== t_ext[i])) begin
          n_bad++;
          $display("FAIL ldext64.%0d: got ill=%0b ext=%h, want ill=%0b ext=%h",
                   i, x64_ill, x64_ext, t_ill[i], t_ext[i]);
        end
      end
      x64_done = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rec_t r;
    r = idle_rec();
    srst = 1'b1; sena = 1'b0;
    iwb_dat = r.iwb; xstb = 1'b0; xwre = 1'b0; xsel = 4'h0; dwb_dti = 32'h0; dwb_ack = 1'b0;
    mpc = r.mpc; malu = r.malu;
    repeat (2) @(posedge sclk);
    #1;
    srst = 1'b0; sena = 1'b1;
    mon_en = 1'b1;

    // phase 1: extension patterns, non-load writeback, illegal lanes, replay/timeout with stall
    phase = "p1";
    add(ins(OPC_LOAD, 3'b000, 5'd5),  1, 0, 4'h4, 32'h0080_0000, 1, 0, 32'h1111, 1, 5,  32'hFFFF_FF80, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b101, 5'd6),  1, 0, 4'hC, 32'h8001_0000, 1, 0, 32'h2222, 1, 6,  32'h0000_8001, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b001, 5'd7),  1, 0, 4'h3, 32'h0000_8001, 1, 0, 32'h3333, 1, 7,  32'hFFFF_8001, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b100, 5'd8),  1, 0, 4'h1, 32'h0000_00F0, 1, 0, 32'h4444, 1, 8,  32'h0000_00F0, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b000, 5'd14), 1, 0, 4'h8, 32'h7F12_3456, 1, 0, 32'h4545, 1, 14, 32'h0000_007F, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd9),  1, 0, 4'hF, 32'hDEAD_BEEF, 1, 0, 32'h5555, 1, 9,  32'hDEAD_BEEF, 0, 0, 0);
    add(ins(OPC_STORE, 3'b010, 5'd3), 1, 1, 4'hF, 32'h0,         1, 0, 32'h0040, 0, 3,  32'h0000_0040, 0, 0, 0);
    add(ins(OPC_BRANCH, 3'b000, 5'd4),0, 0, 4'h0, 32'h0,         0, 0, 32'h0044, 0, 4,  32'h0000_0044, 0, 0, 0);
    add(ins(OPC_OPIMM, 3'b000, 5'd0), 0, 0, 4'h0, 32'h0,         0, 0, 32'h0055, 0, 0,  32'h0000_0055, 0, 0, 0);
    add(ins(OPC_OPIMM, 3'b000, 5'd7), 0, 0, 4'h0, 32'h0,         0, 0, 32'h1234, 1, 7,  32'h0000_1234, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd0),  1, 0, 4'hF, 32'h0000_00AA, 1, 0, 32'h6666, 0, 0,  32'h0000_00AA, 0, 0, 0);
    add(ins(OPC_LOAD, 3'b001, 5'd10), 1, 0, 4'h6, 32'hFFFF_FFFF, 1, 0, 32'h7777, 0, 10, 32'h0,         0, 1, 0);
    add(ins(OPC_LOAD, 3'b011, 5'd11), 1, 0, 4'hF, 32'hFFFF_FFFF, 1, 0, 32'h8888, 0, 11, 32'h0,         0, 1, 0);
    add(ins(OPC_LOAD, 3'b000, 5'd15), 1, 0, 4'h0, 32'hFFFF_FFFF, 1, 0, 32'h9999, 0, 15, 32'h0,         0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0900 + k, 0, 12, 32'h0, 1, 0, k == 8);
      if (k == 5) begin
        add(ins(OPC_LOAD, 3'b010, 5'd13), 1, 0, 4'hF, 32'hCAFE_0001, 0, 1, 32'h0A00, 0, 13, 32'h0,         1, 0, 0);
        add(ins(OPC_LOAD, 3'b010, 5'd13), 1, 0, 4'hF, 32'h0000_1001, 1, 1, 32'h0A01, 1, 13, 32'h0000_1001, 0, 0, 0);
      end
    end
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0B00, 0, 12, 32'h0,         0, 1, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0B01, 0, 12, 32'h0,         1, 0, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'h0000_0077, 1, 2, 32'h0B02, 1, 12, 32'h0000_0077, 0, 0, 0);
    run(2);

    // phase 2: build cnt[2] to 14 and leave a nak'd hart-2 load in M when reset hits
    phase = "p2";
    vec.delete();
    for (int k = 1; k <= 15; k++)
      add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0C00 + k, 0, 12, 32'h0, 1, 0, 0);
    run(1);
    do_reset();

    // phase 3: counters must restart from zero after reset
    phase = "p3";
    vec.delete();
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0D00, 0, 12, 32'h0,         1, 0, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'hCAFE_0000, 0, 2, 32'h0D01, 0, 12, 32'h0,         1, 0, 0);
    add(ins(OPC_LOAD, 3'b010, 5'd12), 1, 0, 4'hF, 32'h0000_0077, 1, 2, 32'h0D02, 1, 12, 32'h0000_0077, 0, 0, 0);
    run(2);

    mon_en = 1'b0;
    end_req = 1'b1;
    repeat (4) @(posedge sclk);
  end

endmodule
